// File: rtl/udcnt_pkg.sv
// udcnt_pkg: mode selectors and widths shared by the up/down modulo counter.
// The optional wrap counter is enabled by defining UDCNT_WRAPCNT_EN.
package udcnt_pkg;

    localparam bit UDCNT_WRAP      = 1'b0;
    localparam bit UDCNT_SAT       = 1'b1;
    localparam int UDCNT_WRAPCNT_W = 16;

endpackage

// File: rtl/udcnt_next.sv
// udcnt_next: combinational next-value and terminal-count logic.
// Works one bit wider than the counter so MOD-1 compares never overflow.
module udcnt_next
    import udcnt_pkg::*;
#(
    parameter int     N_WIDTH = 4,
    parameter longint MOD     = longint'(1) << N_WIDTH,
    parameter bit     SAT     = UDCNT_WRAP
) (
    input  logic [N_WIDTH-1:0] i_y,
    input  logic               i_up,
    input  logic               i_en,
    output logic [N_WIDTH-1:0] o_nxt,
    output logic               o_tc
);

    localparam logic [N_WIDTH:0] TOP = {1'b0, N_WIDTH'(MOD - 1)};

    logic [N_WIDTH:0] w_y;
    logic [N_WIDTH:0] w_nxt;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_unused;

    assign w_y       = {1'b0, i_y};
    assign w_at_top  = (w_y == TOP);
    assign w_at_zero = (w_y == '0);
    assign o_tc      = i_en & (i_up ? w_at_top : w_at_zero);

    always_comb begin
        w_nxt = w_y;
        if (i_en) begin
            if (i_up) begin
                if (w_at_top)
                    w_nxt = (SAT == UDCNT_SAT) ? TOP : '0;
                else
                    w_nxt = w_y + 1'b1;
            end else begin
                if (w_at_zero)
                    w_nxt = (SAT == UDCNT_SAT) ? '0 : TOP;
                else
                    w_nxt = w_y - 1'b1;
            end
        end
    end

    // Top bit is always zero since the value never leaves 0..MOD-1.
    assign o_nxt    = w_nxt[N_WIDTH-1:0];
    assign w_unused = w_nxt[N_WIDTH];

endmodule

// File: rtl/udcnt_mod.sv
// udcnt_mod: up/down modulo counter with wrap or saturate mode and cascade tc.
// Define UDCNT_WRAPCNT_EN to add the 16-bit wrap_cnt event counter output.
module udcnt_mod
    import udcnt_pkg::*;
#(
    parameter int                N_WIDTH   = 4,
    parameter longint            MOD       = longint'(1) << N_WIDTH,
    parameter bit                SAT       = UDCNT_WRAP,
    parameter logic [N_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [N_WIDTH-1:0] load_val,
    output logic [N_WIDTH-1:0] y,
    output logic               tc,
    output logic               ovf
`ifdef UDCNT_WRAPCNT_EN
    ,
    output logic [UDCNT_WRAPCNT_W-1:0] wrap_cnt
`endif
);

    localparam logic [N_WIDTH-1:0] TOP = N_WIDTH'(MOD - 1);

    logic [N_WIDTH-1:0] r_y;
    logic               r_ovf;
    logic [N_WIDTH-1:0] w_nxt;
    logic [N_WIDTH-1:0] w_ld;
    logic               w_tc;

    udcnt_next #(
        .N_WIDTH (N_WIDTH),
        .MOD     (MOD),
        .SAT     (SAT)
    ) u_next (
        .i_y   (r_y),
        .i_up  (up),
        .i_en  (en),
        .o_nxt (w_nxt),
        .o_tc  (w_tc)
    );

    assign w_ld = (load_val > TOP) ? TOP : load_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y   <= RESET_VAL;
            r_ovf <= 1'b0;
        end else if (clear) begin
            r_y   <= RESET_VAL;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_y   <= w_ld;
            r_ovf <= 1'b0;
        end else begin
            r_y   <= w_nxt;
            r_ovf <= w_tc;
        end
    end

    assign y   = r_y;
    assign tc  = w_tc;
    assign ovf = r_ovf;

`ifdef UDCNT_WRAPCNT_EN
    logic [UDCNT_WRAPCNT_W-1:0] r_wrap_cnt;

    // Bumped on the same edge that raises ovf, so it tracks pulses in step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wrap_cnt <= '0;
        else if (clear)
            r_wrap_cnt <= '0;
        else if (!load && w_tc && (r_wrap_cnt != '1))
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end

    assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_udcnt_mod.sv
// tb_udcnt_mod: scoreboard bench for udcnt_mod in wrap and saturate modes.
// Covers the wrap_cnt feature when UDCNT_WRAPCNT_EN is defined.
module tb_udcnt_mod;
    import udcnt_pkg::*;

    typedef struct packed {
        logic [3:0] y;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, clear, en, up, load;
    logic [3:0] load_val;
    logic [3:0] y_w, y_s, y_m;
    logic       tc_w, tc_s, tc_m;
    logic       ovf_w, ovf_s, ovf_m;
`ifdef UDCNT_WRAPCNT_EN
    logic [15:0] wc_w, wc_s, wc_m;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q_w[$];
    exp_t q_s[$];

    always #5 clk = ~clk;

    udcnt_mod #(.N_WIDTH(4), .MOD(10), .SAT(UDCNT_WRAP), .RESET_VAL(4'd0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up),
        .load(load), .load_val(load_val), .y(y_w), .tc(tc_w), .ovf(ovf_w)
`ifdef UDCNT_WRAPCNT_EN
        , .wrap_cnt(wc_w)
`endif
    );

    udcnt_mod #(.N_WIDTH(4), .MOD(10), .SAT(UDCNT_SAT), .RESET_VAL(4'd3)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up),
        .load(load), .load_val(load_val), .y(y_s), .tc(tc_s), .ovf(ovf_s)
`ifdef UDCNT_WRAPCNT_EN
        , .wrap_cnt(wc_s)
`endif
    );

    udcnt_mod #(.N_WIDTH(4), .MOD(2), .SAT(UDCNT_WRAP), .RESET_VAL(4'd0)) u_m2 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .up(up),
        .load(load), .load_val(load_val), .y(y_m), .tc(tc_m), .ovf(ovf_m)
`ifdef UDCNT_WRAPCNT_EN
        , .wrap_cnt(wc_m)
`endif
    );

    task automatic drive(input logic c, input logic l, input logic e,
                         input logic u, input logic [3:0] v);
        clear = c; load = l; en = e; up = u; load_val = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 1, 1, 4'd0);
        #3;
        checks++;
        if (y_w !== 4'd0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap got y=%0d ovf=%0b want y=0 ovf=0", y_w, ovf_w);
        end
        checks++;
        if (y_s !== 4'd3 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat got y=%0d ovf=%0b want y=3 ovf=0", y_s, ovf_s);
        end
        tick();
        checks++;
        if (y_w !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold got y=%0d want 0", y_w);
        end
        #2;
        reset = 1'b0;
    endtask

    task automatic test_up_wrap();
        int   ys[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1, 1, 4'd0);
            #1;
            checks++;
            if (tc_w !== (i == 9)) begin
                errors++;
                $display("FAIL up_wrap_tc[%0d] got %0b want %0b", i, tc_w, (i == 9));
            end
            q_w.push_back(exp_t'{y: 4'(ys[i]), ovf: (i == 9)});
            tick();
            e = q_w.pop_front();
            checks++;
            if (y_w !== e.y || ovf_w !== e.ovf) begin
                errors++;
                $display("FAIL up_wrap[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_w, ovf_w, e.y, e.ovf);
            end
        end
    endtask

    task automatic test_down_wrap();
        int   ys[4] = '{1, 0, 9, 8};
        exp_t e;
        drive(0, 1, 0, 0, 4'd2);
        tick();
        checks++;
        if (y_w !== 4'd2 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL down_load got y=%0d ovf=%0b want y=2 ovf=0", y_w, ovf_w);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0, 4'd0);
            #1;
            checks++;
            if (tc_w !== (i == 2)) begin
                errors++;
                $display("FAIL down_tc[%0d] got %0b want %0b", i, tc_w, (i == 2));
            end
            q_w.push_back(exp_t'{y: 4'(ys[i]), ovf: (i == 2)});
            tick();
            e = q_w.pop_front();
            checks++;
            if (y_w !== e.y || ovf_w !== e.ovf) begin
                errors++;
                $display("FAIL down_wrap[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_w, ovf_w, e.y, e.ovf);
            end
        end
    endtask

    task automatic test_saturate();
        int   yw[4] = '{9, 0, 1, 2};
        exp_t e;
        drive(0, 1, 0, 0, 4'd8);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 4'd0);
            #1;
            checks++;
            if (tc_s !== (i >= 1)) begin
                errors++;
                $display("FAIL sat_up_tc[%0d] got %0b want %0b", i, tc_s, (i >= 1));
            end
            q_s.push_back(exp_t'{y: 4'd9, ovf: (i >= 1)});
            q_w.push_back(exp_t'{y: 4'(yw[i]), ovf: (i == 1)});
            tick();
            e = q_s.pop_front();
            checks++;
            if (y_s !== e.y || ovf_s !== e.ovf) begin
                errors++;
                $display("FAIL sat_up[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_s, ovf_s, e.y, e.ovf);
            end
            e = q_w.pop_front();
            checks++;
            if (y_w !== e.y || ovf_w !== e.ovf) begin
                errors++;
                $display("FAIL sat_cmp_wrap[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_w, ovf_w, e.y, e.ovf);
            end
        end
        drive(0, 1, 0, 0, 4'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 4'd0);
            q_s.push_back(exp_t'{y: 4'd0, ovf: (i >= 1)});
            tick();
            e = q_s.pop_front();
            checks++;
            if (y_s !== e.y || ovf_s !== e.ovf) begin
                errors++;
                $display("FAIL sat_down[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_s, ovf_s, e.y, e.ovf);
            end
        end
    endtask

    task automatic test_clear_load();
        logic [3:0] lv[3] = '{4'd14, 4'd10, 4'd4};
        logic [3:0] ly[3] = '{4'd9, 4'd9, 4'd4};
        drive(1, 1, 1, 1, 4'd5);
        tick();
        checks++;
        if (y_w !== 4'd0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL clear_prio_wrap got y=%0d ovf=%0b want y=0 ovf=0", y_w, ovf_w);
        end
        checks++;
        if (y_s !== 4'd3 || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL clear_prio_sat got y=%0d ovf=%0b want y=3 ovf=0", y_s, ovf_s);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, lv[i]);
            tick();
            checks++;
            if (y_w !== ly[i] || ovf_w !== 1'b0) begin
                errors++;
                $display("FAIL load_clamp[%0d] got y=%0d ovf=%0b want y=%0d ovf=0",
                         i, y_w, ovf_w, ly[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       dir[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int         ys[5] = '{5, 4, 3, 4, 5};
        exp_t       e;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, dir[i], 4'd0);
            q_w.push_back(exp_t'{y: 4'(ys[i]), ovf: 1'b0});
            tick();
            e = q_w.pop_front();
            checks++;
            if (y_w !== e.y || ovf_w !== e.ovf) begin
                errors++;
                $display("FAIL b2b[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_w, ovf_w, e.y, e.ovf);
            end
        end
        drive(0, 1, 0, 1, 4'd9);
        tick();
        drive(0, 0, 0, 1, 4'd0);
        #1;
        checks++;
        if (tc_w !== 1'b0) begin
            errors++;
            $display("FAIL tc_en_low got %0b want 0", tc_w);
        end
        tick();
        checks++;
        if (y_w !== 4'd9 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL hold got y=%0d ovf=%0b want y=9 ovf=0", y_w, ovf_w);
        end
        drive(0, 0, 1, 1, 4'd0);
        #1;
        checks++;
        if (tc_w !== 1'b1) begin
            errors++;
            $display("FAIL tc_en_high got %0b want 1", tc_w);
        end
        tick();
        checks++;
        if (y_w !== 4'd0 || ovf_w !== 1'b1) begin
            errors++;
            $display("FAIL wrap_after_hold got y=%0d ovf=%0b want y=0 ovf=1", y_w, ovf_w);
        end
    endtask

    task automatic test_async_reset();
        int   yw[2] = '{1, 2};
        int   yy[2] = '{4, 5};
        exp_t e;
        drive(0, 1, 0, 1, 4'd7);
        tick();
        #3;
        reset = 1'b1;
        drive(0, 0, 1, 1, 4'd0);
        #1;
        checks++;
        if (y_w !== 4'd0 || ovf_w !== 1'b0 || y_s !== 4'd3) begin
            errors++;
            $display("FAIL async_reset got y=%0d ovf=%0b ys=%0d want y=0 ovf=0 ys=3",
                     y_w, ovf_w, y_s);
        end
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q_w.push_back(exp_t'{y: 4'(yw[i]), ovf: 1'b0});
            q_s.push_back(exp_t'{y: 4'(yy[i]), ovf: 1'b0});
            tick();
            e = q_w.pop_front();
            checks++;
            if (y_w !== e.y || ovf_w !== e.ovf) begin
                errors++;
                $display("FAIL resume_wrap[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_w, ovf_w, e.y, e.ovf);
            end
            e = q_s.pop_front();
            checks++;
            if (y_s !== e.y || ovf_s !== e.ovf) begin
                errors++;
                $display("FAIL resume_sat[%0d] got y=%0d ovf=%0b want y=%0d ovf=%0b",
                         i, y_s, ovf_s, e.y, e.ovf);
            end
        end
    endtask

`ifdef UDCNT_WRAPCNT_EN
    task automatic test_wrapcnt();
        drive(0, 0, 1, 1, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        checks++;
        if (wc_m !== 16'd0) begin
            errors++;
            $display("FAIL wrapcnt_reset got %0d want 0", wc_m);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (wc_m !== 16'd5 || y_m !== 4'd0) begin
            errors++;
            $display("FAIL wrapcnt_count got wc=%0d y=%0d want wc=5 y=0", wc_m, y_m);
        end
        drive(1, 0, 1, 1, 4'd0);
        tick();
        checks++;
        if (wc_m !== 16'd0) begin
            errors++;
            $display("FAIL wrapcnt_clear got %0d want 0", wc_m);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_clear_load();
        test_back_to_back();
        test_async_reset();
`ifdef UDCNT_WRAPCNT_EN
        test_wrapcnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
